l2_status_regs_p: RTL and testbench

//  Parametrised successor of the L2 controller status/credit register bank; sits beside the L2 FSM.

---
 rtl/l2_status_regs_p.sv | 235 +++++++++++++++++++++++
 tb/tb_l2_status_regs_p.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_status_regs_p.sv
// L2 controller status/credit register bank: MSHR and write-buffer credits, flag vector,
// forward-stall slots and a self-sequencing set/way flush sweep.
module l2_status_regs_p #(
    parameter int N_MSHR  = 16,
    parameter int N_WB    = 4,
    parameter int N_FWD   = 2,
    parameter int N_FLAG  = 5,
    parameter int L2_SETS = 512,
    parameter int L2_WAYS = 8,
    localparam int MW = $clog2(N_MSHR),
    localparam int BW = $clog2(N_WB),
    localparam int SW = $clog2(L2_SETS),
    localparam int WW = $clog2(L2_WAYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mshr_alloc,
    input  logic              mshr_free,
    input  logic [MW-1:0]     mshr_free_idx,
    output logic [MW:0]       mshr_cnt,
    output logic              mshr_none,
    output logic              cred_err,
    input  logic [N_FLAG-1:0] flag_set,
    input  logic [N_FLAG-1:0] flag_clr,
    output logic [N_FLAG-1:0] flags,
    input  logic              fwd_set,
    input  logic [MW-1:0]     fwd_set_idx,
    input  logic [N_FWD-1:0]  fwd_clr,
    output logic [N_FWD-1:0]  fwd_valid,
    output logic [N_FWD-1:0]  fwd_ended,
    output logic              fwd_full,
    input  logic              flush_start,
    input  logic              flush_step,
    input  logic              flush_abort,
    output logic              ongoing_flush,
    output logic [SW-1:0]     flush_set,
    output logic [WW-1:0]     flush_way,
    output logic              flush_done,
    input  logic              wb_alloc,
    input  logic              wb_hit,
    input  logic              wb_free,
    output logic [BW:0]       wb_cnt,
    output logic [BW-1:0]     wb_evict_ptr
);

    localparam logic [MW:0]   MSHR_MAX = (MW+1)'(N_MSHR);
    localparam logic [BW:0]   WB_MAX   = (BW+1)'(N_WB);
    localparam logic [BW-1:0] WB_PTR0  = BW'(N_WB - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(L2_SETS - 1);
    localparam logic [WW-1:0] WAY_LAST = WW'(L2_WAYS - 1);

    typedef enum logic [0:0] {FL_IDLE = 1'b0, FL_SWEEP = 1'b1} fl_state_t;

    logic [MW:0]     mshr_nxt_s;
    logic            mshr_err_s;
    logic [BW:0]     wb_nxt_s;
    logic            wb_err_s;
    logic            wb_alloc_eff_s;
    logic [N_FWD-1:0] fwd_take_s;
    logic            fwd_found_s;
    logic            fwd_err_s;
    logic [MW-1:0]   fwd_entry_r [N_FWD];
    fl_state_t       fl_state_r;
    fl_state_t       fl_state_nxt_s;
    logic [SW-1:0]   set_nxt_s;
    logic [WW-1:0]   way_nxt_s;
    logic            done_nxt_s;

    assign mshr_none      = (mshr_cnt == '0);
    assign fwd_full       = &fwd_valid;
    assign wb_alloc_eff_s = wb_alloc & ~wb_hit;

    // MSHR credit next value; a simultaneous alloc and free cancel out
    always_comb begin
        mshr_nxt_s = mshr_cnt;
        mshr_err_s = 1'b0;
        if (mshr_alloc && !mshr_free) begin
            if (mshr_cnt == '0) mshr_err_s = 1'b1;
            else                mshr_nxt_s = mshr_cnt - 1'b1;
        end else if (mshr_free && !mshr_alloc) begin
            if (mshr_cnt == MSHR_MAX) mshr_err_s = 1'b1;
            else                      mshr_nxt_s = mshr_cnt + 1'b1;
        end else begin
            mshr_nxt_s = mshr_cnt;
        end
    end

    // Write-buffer credit next value; merging inserts consume no credit
    always_comb begin
        wb_nxt_s = wb_cnt;
        wb_err_s = 1'b0;
        if (wb_alloc_eff_s && !wb_free) begin
            if (wb_cnt == '0) wb_err_s = 1'b1;
            else              wb_nxt_s = wb_cnt - 1'b1;
        end else if (wb_free && !wb_alloc_eff_s) begin
            if (wb_cnt == WB_MAX) wb_err_s = 1'b1;
            else                  wb_nxt_s = wb_cnt + 1'b1;
        end else begin
            wb_nxt_s = wb_cnt;
        end
    end

    // Lowest open slot for a new forward stall; slots being cleared this cycle are skipped
    always_comb begin
        fwd_take_s  = '0;
        fwd_found_s = 1'b0;
        for (int i = 0; i < N_FWD; i++) begin
            if (!fwd_valid[i] && !fwd_clr[i] && !fwd_found_s) begin
                fwd_take_s[i] = 1'b1;
                fwd_found_s   = 1'b1;
            end else begin
                fwd_take_s[i] = 1'b0;
            end
        end
        if (!fwd_set || fwd_full) begin
            fwd_take_s = '0;
        end else begin
            fwd_take_s = fwd_take_s;
        end
        fwd_err_s = fwd_set & fwd_full;
    end

    // Credits, flags, sticky error and evict pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mshr_cnt     <= MSHR_MAX;
            wb_cnt       <= WB_MAX;
            wb_evict_ptr <= WB_PTR0;
            cred_err     <= 1'b0;
            flags        <= '0;
        end else begin
            mshr_cnt <= mshr_nxt_s;
            wb_cnt   <= wb_nxt_s;
            cred_err <= cred_err | mshr_err_s | wb_err_s | fwd_err_s;
            flags    <= (flags | flag_set) & ~flag_clr;
            if (wb_free && !flags[3]) wb_evict_ptr <= wb_evict_ptr + 1'b1;
        end
    end

    // Forward-stall slots: clear beats open and beats the ended update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_valid <= '0;
            fwd_ended <= '0;
            for (int i = 0; i < N_FWD; i++) fwd_entry_r[i] <= '0;
        end else begin
            for (int i = 0; i < N_FWD; i++) begin
                if (fwd_clr[i]) begin
                    fwd_valid[i] <= 1'b0;
                    fwd_ended[i] <= 1'b0;
                end else if (fwd_take_s[i]) begin
                    fwd_valid[i]   <= 1'b1;
                    fwd_ended[i]   <= 1'b0;
                    fwd_entry_r[i] <= fwd_set_idx;
                end else if (fwd_valid[i] && mshr_free && (fwd_entry_r[i] == mshr_free_idx)) begin
                    fwd_ended[i] <= 1'b1;
                end
            end
        end
    end

    // Flush FSM state and registered sweep outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fl_state_r    <= FL_IDLE;
            ongoing_flush <= 1'b0;
            flush_set     <= '0;
            flush_way     <= '0;
            flush_done    <= 1'b0;
        end else begin
            fl_state_r    <= fl_state_nxt_s;
            ongoing_flush <= (fl_state_nxt_s == FL_SWEEP);
            flush_set     <= set_nxt_s;
            flush_way     <= way_nxt_s;
            flush_done    <= done_nxt_s;
        end
    end

    // Flush FSM next state; abort beats step, start is ignored while sweeping
    always_comb begin
        fl_state_nxt_s = fl_state_r;
        case (fl_state_r)
            FL_IDLE: begin
                if (flush_start) fl_state_nxt_s = FL_SWEEP;
                else             fl_state_nxt_s = FL_IDLE;
            end
            FL_SWEEP: begin
                if (flush_abort)
                    fl_state_nxt_s = FL_IDLE;
                else if (flush_step && flush_way == WAY_LAST && flush_set == SET_LAST)
                    fl_state_nxt_s = FL_IDLE;
                else
                    fl_state_nxt_s = FL_SWEEP;
            end
            default: fl_state_nxt_s = FL_IDLE;
        endcase
    end

    // Flush FSM output values: set/way walk and completion pulse
    always_comb begin
        set_nxt_s  = flush_set;
        way_nxt_s  = flush_way;
        done_nxt_s = 1'b0;
        case (fl_state_r)
            FL_IDLE: begin
                set_nxt_s = '0;
                way_nxt_s = '0;
            end
            FL_SWEEP: begin
                if (flush_abort) begin
                    set_nxt_s = '0;
                    way_nxt_s = '0;
                end else if (flush_step) begin
                    if (flush_way != WAY_LAST) begin
                        way_nxt_s = flush_way + 1'b1;
                    end else if (flush_set != SET_LAST) begin
                        way_nxt_s = '0;
                        set_nxt_s = flush_set + 1'b1;
                    end else begin
                        way_nxt_s  = '0;
                        set_nxt_s  = '0;
                        done_nxt_s = 1'b1;
                    end
                end else begin
                    set_nxt_s = flush_set;
                end
            end
            default: begin
                set_nxt_s = '0;
                way_nxt_s = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_l2_status_regs_p.sv
// Directed bench for l2_status_regs_p: vector table for credits/flags/fwd slots/WB,
// hand sequences for reset, counter saturation and the flush sweep.
module tb_l2_status_regs_p;

    logic       clk = 1'b0;
    logic       rst;
    logic       mshr_alloc, mshr_free;
    logic [3:0] mshr_free_idx;
    logic [4:0] mshr_cnt;
    logic       mshr_none, cred_err;
    logic [4:0] flag_set, flag_clr, flags;
    logic       fwd_set;
    logic [3:0] fwd_set_idx;
    logic [1:0] fwd_clr, fwd_valid, fwd_ended;
    logic       fwd_full;
    logic       flush_start, flush_step, flush_abort, ongoing_flush, flush_done;
    logic [1:0] flush_set;
    logic [0:0] flush_way;
    logic       wb_alloc, wb_hit, wb_free;
    logic [2:0] wb_cnt;
    logic [1:0] wb_evict_ptr;

    int n_cmp = 0;
    int n_bad = 0;

    l2_status_regs_p #(.N_MSHR(16), .N_WB(4), .N_FWD(2), .N_FLAG(5), .L2_SETS(4), .L2_WAYS(2)) dut (
        .clk(clk), .rst(rst),
        .mshr_alloc(mshr_alloc), .mshr_free(mshr_free), .mshr_free_idx(mshr_free_idx),
        .mshr_cnt(mshr_cnt), .mshr_none(mshr_none), .cred_err(cred_err),
        .flag_set(flag_set), .flag_clr(flag_clr), .flags(flags),
        .fwd_set(fwd_set), .fwd_set_idx(fwd_set_idx), .fwd_clr(fwd_clr),
        .fwd_valid(fwd_valid), .fwd_ended(fwd_ended), .fwd_full(fwd_full),
        .flush_start(flush_start), .flush_step(flush_step), .flush_abort(flush_abort),
        .ongoing_flush(ongoing_flush), .flush_set(flush_set), .flush_way(flush_way),
        .flush_done(flush_done),
        .wb_alloc(wb_alloc), .wb_hit(wb_hit), .wb_free(wb_free),
        .wb_cnt(wb_cnt), .wb_evict_ptr(wb_evict_ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ma, mf, mfi, fs, fc, ws, wsi, wc, wa, wh, wf;
        int cnt, err, flg, fv, fe, full, wbc, ptr;
    } vec_t;

    vec_t tbl[34];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mshr_alloc = 1'b0; mshr_free = 1'b0; mshr_free_idx = 4'd0;
        flag_set = 5'd0; flag_clr = 5'd0;
        fwd_set = 1'b0; fwd_set_idx = 4'd0; fwd_clr = 2'd0;
        flush_start = 1'b0; flush_step = 1'b0; flush_abort = 1'b0;
        wb_alloc = 1'b0; wb_hit = 1'b0; wb_free = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " mshr_cnt"}, int'(mshr_cnt), 16);
        chk({tag, " mshr_none"}, int'(mshr_none), 0);
        chk({tag, " cred_err"}, int'(cred_err), 0);
        chk({tag, " flags"}, int'(flags), 0);
        chk({tag, " fwd_valid"}, int'(fwd_valid), 0);
        chk({tag, " fwd_ended"}, int'(fwd_ended), 0);
        chk({tag, " fwd_full"}, int'(fwd_full), 0);
        chk({tag, " ongoing"}, int'(ongoing_flush), 0);
        chk({tag, " flush_set"}, int'(flush_set), 0);
        chk({tag, " flush_way"}, int'(flush_way), 0);
        chk({tag, " flush_done"}, int'(flush_done), 0);
        chk({tag, " wb_cnt"}, int'(wb_cnt), 4);
        chk({tag, " wb_ptr"}, int'(wb_evict_ptr), 3);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic flush_pos(input string nm, input int ong, input int s, input int w, input int d);
        chk({nm, " ongoing"}, int'(ongoing_flush), ong);
        chk({nm, " set"}, int'(flush_set), s);
        chk({nm, " way"}, int'(flush_way), w);
        chk({nm, " done"}, int'(flush_done), d);
    endtask

    initial begin
        //            ma mf mfi fs fc ws wsi wc wa wh wf   cnt err flg fv fe full wbc ptr
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   15, 0, 0, 0, 0, 0, 4, 3};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   14, 0, 0, 0, 0, 0, 4, 3};
        tbl[2]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   14, 0, 0, 0, 0, 0, 4, 3};
        tbl[3]  = '{1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0,   13, 0, 0, 1, 0, 0, 4, 3};
        tbl[4]  = '{0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0,   13, 0, 0, 3, 0, 1, 4, 3};
        tbl[5]  = '{0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0,   14, 0, 0, 3, 2, 1, 4, 3};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0,   14, 0, 0, 1, 0, 0, 4, 3};
        tbl[7]  = '{0, 1, 3, 0, 0, 1, 5, 1, 0, 0, 0,   15, 0, 0, 2, 0, 0, 4, 3};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0,   15, 0, 0, 3, 0, 1, 4, 3};
        tbl[9]  = '{0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0,   16, 0, 0, 3, 2, 1, 4, 3};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0,   16, 1, 0, 3, 2, 1, 4, 3};
        tbl[11] = '{0, 1, 9, 0, 0, 0, 0, 3, 0, 0, 0,   16, 1, 0, 0, 0, 0, 4, 3};
        tbl[12] = '{0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0,   16, 1, 0, 1, 0, 0, 4, 3};
        tbl[13] = '{1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0,   15, 1, 0, 3, 0, 1, 4, 3};
        tbl[14] = '{0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0,   16, 1, 0, 3, 3, 1, 4, 3};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0,   16, 1, 0, 0, 0, 0, 4, 3};
        tbl[16] = '{0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0,   16, 1, 5, 0, 0, 0, 4, 3};
        tbl[17] = '{0, 0, 0, 4, 4, 0, 0, 0, 0, 0, 0,   16, 1, 1, 0, 0, 0, 4, 3};
        tbl[18] = '{0, 0, 0, 24, 1, 0, 0, 0, 0, 0, 0,  16, 1, 24, 0, 0, 0, 4, 3};
        tbl[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   16, 1, 24, 0, 0, 0, 4, 3};
        tbl[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   16, 1, 24, 0, 0, 0, 3, 3};
        tbl[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   16, 1, 24, 0, 0, 0, 3, 3};
        tbl[22] = '{0, 0, 0, 0, 31, 0, 0, 0, 0, 0, 0,  16, 1, 0, 0, 0, 0, 3, 3};
        tbl[23] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   16, 1, 0, 0, 0, 0, 4, 0};
        tbl[24] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   16, 1, 0, 0, 0, 0, 4, 1};
        tbl[25] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   16, 1, 0, 0, 0, 0, 4, 2};
        tbl[26] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   16, 1, 0, 0, 0, 0, 4, 3};
        tbl[27] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   16, 1, 0, 0, 0, 0, 4, 0};
        tbl[28] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,   16, 1, 0, 0, 0, 0, 4, 1};
        tbl[29] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   16, 1, 0, 0, 0, 0, 3, 1};
        tbl[30] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   16, 1, 0, 0, 0, 0, 2, 1};
        tbl[31] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   16, 1, 0, 0, 0, 0, 1, 1};
        tbl[32] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   16, 1, 0, 0, 0, 0, 0, 1};
        tbl[33] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   16, 1, 0, 0, 0, 0, 0, 1};

        // Reset state
        idle_inputs();
        rst = 1'b0;
        #12;
        check_reset_values("reset");
        rst = 1'b1;

        // MSHR overflow on a full counter
        tick();
        mshr_free = 1'b1; mshr_free_idx = 4'd2;
        tick();
        idle_inputs();
        chk("mshr_ovf cnt", int'(mshr_cnt), 16);
        chk("mshr_ovf err", int'(cred_err), 1);

        // WB overflow sets the sticky error and still advances the pointer
        do_reset();
        wb_free = 1'b1;
        tick();
        idle_inputs();
        chk("wb_ovf cnt", int'(wb_cnt), 4);
        chk("wb_ovf err", int'(cred_err), 1);
        chk("wb_ovf ptr", int'(wb_evict_ptr), 0);

        // Drain all MSHR credits, then underflow
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mshr_alloc = 1'b1;
            tick();
            chk("alloc cnt", int'(mshr_cnt), 15 - i);
        end
        chk("drained none", int'(mshr_none), 1);
        chk("drained err", int'(cred_err), 0);
        tick();
        idle_inputs();
        chk("udf cnt", int'(mshr_cnt), 0);
        chk("udf err", int'(cred_err), 1);
        chk("udf none", int'(mshr_none), 1);

        // Table-driven vectors from a fresh reset
        do_reset();
        for (int v = 0; v < 34; v++) begin
            mshr_alloc    = 1'(tbl[v].ma);
            mshr_free     = 1'(tbl[v].mf);
            mshr_free_idx = 4'(tbl[v].mfi);
            flag_set      = 5'(tbl[v].fs);
            flag_clr      = 5'(tbl[v].fc);
            fwd_set       = 1'(tbl[v].ws);
            fwd_set_idx   = 4'(tbl[v].wsi);
            fwd_clr       = 2'(tbl[v].wc);
            wb_alloc      = 1'(tbl[v].wa);
            wb_hit        = 1'(tbl[v].wh);
            wb_free       = 1'(tbl[v].wf);
            tick();
            idle_inputs();
            chk($sformatf("v%0d mshr_cnt", v), int'(mshr_cnt), tbl[v].cnt);
            chk($sformatf("v%0d mshr_none", v), int'(mshr_none), (tbl[v].cnt == 0) ? 1 : 0);
            chk($sformatf("v%0d cred_err", v), int'(cred_err), tbl[v].err);
            chk($sformatf("v%0d flags", v), int'(flags), tbl[v].flg);
            chk($sformatf("v%0d fwd_valid", v), int'(fwd_valid), tbl[v].fv);
            chk($sformatf("v%0d fwd_ended", v), int'(fwd_ended), tbl[v].fe);
            chk($sformatf("v%0d fwd_full", v), int'(fwd_full), tbl[v].full);
            chk($sformatf("v%0d wb_cnt", v), int'(wb_cnt), tbl[v].wbc);
            chk($sformatf("v%0d wb_ptr", v), int'(wb_evict_ptr), tbl[v].ptr);
        end

        // Full flush sweep over 4 sets x 2 ways; start during sweep is ignored
        flush_start = 1'b1;
        tick();
        idle_inputs();
        flush_pos("fl_start", 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            flush_step  = 1'b1;
            flush_start = (k == 3) ? 1'b1 : 1'b0;
            tick();
            idle_inputs();
            if (k < 8) flush_pos($sformatf("fl_step%0d", k), 1, k / 2, k % 2, 0);
            else       flush_pos("fl_last", 0, 0, 0, 1);
        end
        tick();
        flush_pos("fl_after", 0, 0, 0, 0);

        // Abort after three steps; abort beats a same-cycle step
        flush_start = 1'b1;
        tick();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            flush_step = 1'b1;
            tick();
            idle_inputs();
        end
        flush_pos("ab_pre", 1, 1, 1, 0);
        flush_abort = 1'b1;
        flush_step  = 1'b1;
        tick();
        idle_inputs();
        flush_pos("ab_now", 0, 0, 0, 0);
        tick();
        flush_pos("ab_after", 0, 0, 0, 0);

        // Asynchronous reset in the middle of a sweep with other state dirty
        do_reset();
        flush_start = 1'b1; mshr_alloc = 1'b1; fwd_set = 1'b1; flag_set = 5'd7; wb_alloc = 1'b1;
        tick();
        idle_inputs();
        flush_step = 1'b1;
        tick();
        tick();
        idle_inputs();
        flush_pos("mid_pre", 1, 1, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("mid_rst");
        tick();
        rst = 1'b1;
        tick();
        check_reset_values("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
